// File: rtl/range_sensor_pkg.sv
// ----------------------------------------------------------------------------
// range_sensor_pkg
// Shared definitions for the ultrasonic range sensor block: register offsets
// inside a sensor slot, CTRL/STATUS bit positions, the per-sensor FSM state
// encoding and the clocks-per-microsecond helper used by the prescaler.
// ----------------------------------------------------------------------------
package range_sensor_pkg;

    // Register offsets within one sensor slot (addr[2:0])
    localparam logic [2:0] REG_CTRL       = 3'd0;
    localparam logic [2:0] REG_STATUS     = 3'd1;
    localparam logic [2:0] REG_ECHO_US    = 3'd2;
    localparam logic [2:0] REG_DIST_CM    = 3'd3;
    localparam logic [2:0] REG_SAMPLE_CNT = 3'd4;

    // CTRL bits
    localparam int CTRL_CONT_BIT  = 0;
    localparam int CTRL_START_BIT = 1;

    // STATUS bits
    localparam int STAT_BUSY_BIT    = 0;
    localparam int STAT_VALID_BIT   = 1;
    localparam int STAT_TIMEOUT_BIT = 2;

    // Per-sensor measurement FSM, fixed encodings
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_TRIG      = 3'd1,
        ST_WAIT_RISE = 3'd2,
        ST_MEASURE   = 3'd3,
        ST_COOL      = 3'd4
    } state_t;

    // Number of system clocks that make up one microsecond tick
    function automatic int us_per_clk(input int clk_freq_hz);
        return clk_freq_hz / 1_000_000;
    endfunction

endpackage

// File: rtl/range_sensor_channel.sv
// ----------------------------------------------------------------------------
// range_sensor_channel
// One HC-SR04 style sensor slot: echo synchronizer, trigger/measure/cool FSM,
// microsecond and centimetre counters, and the slot's result registers.
// Ports:
//   i_clk, i_rst      clock, synchronous active-high reset
//   i_tick            shared 1 us strobe from the top-level prescaler
//   i_wr_ctrl         write strobe for CTRL, with i_cont / i_start data bits
//   i_wr_status       write strobe for STATUS (clears VALID and TIMEOUT)
//   i_echo            asynchronous echo input
//   o_trig            registered trigger output
//   o_cont .. o_sample_cnt  register contents for the top-level read mux
// ----------------------------------------------------------------------------
module range_sensor_channel #(
    parameter int TRIG_US    = 10,
    parameter int TIMEOUT_US = 30000,
    parameter int CM_DIV_US  = 58,
    parameter int COOL_TICKS = 60000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_tick,
    input  logic        i_wr_ctrl,
    input  logic        i_wr_status,
    input  logic        i_cont,
    input  logic        i_start,
    input  logic        i_echo,
    output logic        o_trig,
    output logic        o_cont,
    output logic        o_busy,
    output logic        o_valid,
    output logic        o_timeout,
    output logic [15:0] o_echo_us,
    output logic [9:0]  o_dist_cm,
    output logic [15:0] o_sample_cnt
);
    import range_sensor_pkg::*;

    localparam logic [31:0] TRIG_LAST    = 32'(TRIG_US - 1);
    localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_US - 1);
    localparam logic [31:0] COOL_LAST    = 32'(COOL_TICKS - 1);
    localparam logic [15:0] TIMEOUT_W    = 16'(TIMEOUT_US);
    localparam logic [7:0]  CM_LAST      = 8'(CM_DIV_US - 1);

    state_t      r_state;
    logic [31:0] r_cnt;
    logic [15:0] r_width;
    logic [7:0]  r_cm_sub;
    logic [9:0]  r_cm;
    logic        r_trig;
    logic        r_cont;
    logic        r_start_pend;
    logic        r_valid;
    logic        r_timeout;
    logic [15:0] r_echo_us;
    logic [9:0]  r_dist_cm;
    logic [15:0] r_sample_cnt;

    logic        r_echo_meta;
    logic        r_echo_sync;
    logic        r_echo_prev;

    logic        w_rise;
    logic        w_fall;
    logic [15:0] w_width_nxt;
    logic [7:0]  w_cm_sub_nxt;
    logic [9:0]  w_cm_nxt;

    // Echo synchronizer and edge-detect history
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_echo_meta <= 1'b0;
            r_echo_sync <= 1'b0;
            r_echo_prev <= 1'b0;
        end else begin
            r_echo_meta <= i_echo;
            r_echo_sync <= r_echo_meta;
            r_echo_prev <= r_echo_sync;
        end
    end

    assign w_rise = r_echo_sync & ~r_echo_prev;
    assign w_fall = ~r_echo_sync & r_echo_prev;

    // Width/cm counters with this clock's tick applied. The tick on the
    // fall clock is included and the one on the rise clock is not, so an
    // echo of N us always measures exactly N regardless of tick phase.
    always_comb begin
        w_width_nxt  = r_width;
        w_cm_sub_nxt = r_cm_sub;
        w_cm_nxt     = r_cm;
        if (i_tick) begin
            w_width_nxt = r_width + 16'd1;
            if (r_cm_sub == CM_LAST) begin
                w_cm_sub_nxt = 8'd0;
                w_cm_nxt     = r_cm + 10'd1;
            end else begin
                w_cm_sub_nxt = r_cm_sub + 8'd1;
                w_cm_nxt     = r_cm;
            end
        end else begin
            w_width_nxt  = r_width;
            w_cm_sub_nxt = r_cm_sub;
            w_cm_nxt     = r_cm;
        end
    end

    // Measurement FSM, result registers and status flags
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= ST_IDLE;
            r_cnt        <= 32'd0;
            r_width      <= 16'd0;
            r_cm_sub     <= 8'd0;
            r_cm         <= 10'd0;
            r_trig       <= 1'b0;
            r_cont       <= 1'b0;
            r_start_pend <= 1'b0;
            r_valid      <= 1'b0;
            r_timeout    <= 1'b0;
            r_echo_us    <= 16'd0;
            r_dist_cm    <= 10'd0;
            r_sample_cnt <= 16'd0;
        end else begin
            if (i_wr_ctrl) begin
                r_cont <= i_cont;
            end
            // START is only honoured while idle; it launches on the next
            // tick so the trigger pulse is a whole number of microseconds.
            if (i_wr_ctrl && i_start && (r_state == ST_IDLE)) begin
                r_start_pend <= 1'b1;
            end
            // Software clear first; hardware sets below override it.
            if (i_wr_status) begin
                r_valid   <= 1'b0;
                r_timeout <= 1'b0;
            end

            case (r_state)
                ST_IDLE: begin
                    if (i_tick && (r_start_pend || r_cont)) begin
                        r_start_pend <= 1'b0;
                        r_trig       <= 1'b1;
                        r_cnt        <= 32'd0;
                        r_state      <= ST_TRIG;
                    end
                end
                ST_TRIG: begin
                    if (i_tick) begin
                        if (r_cnt == TRIG_LAST) begin
                            r_trig  <= 1'b0;
                            r_cnt   <= 32'd0;
                            r_state <= ST_WAIT_RISE;
                        end else begin
                            r_cnt <= r_cnt + 32'd1;
                        end
                    end
                end
                ST_WAIT_RISE: begin
                    if (w_rise) begin
                        r_width  <= 16'd0;
                        r_cm_sub <= 8'd0;
                        r_cm     <= 10'd0;
                        r_cnt    <= 32'd0;
                        r_state  <= ST_MEASURE;
                    end else if (i_tick) begin
                        if (r_cnt == TIMEOUT_LAST) begin
                            r_timeout <= 1'b1;
                            r_cnt     <= 32'd0;
                            r_state   <= ST_COOL;
                        end else begin
                            r_cnt <= r_cnt + 32'd1;
                        end
                    end
                end
                ST_MEASURE: begin
                    if (w_fall) begin
                        r_echo_us    <= w_width_nxt;
                        r_dist_cm    <= w_cm_nxt;
                        r_valid      <= 1'b1;
                        r_sample_cnt <= r_sample_cnt + 16'd1;
                        r_cnt        <= 32'd0;
                        r_state      <= ST_COOL;
                    end else if (i_tick) begin
                        r_width  <= w_width_nxt;
                        r_cm_sub <= w_cm_sub_nxt;
                        r_cm     <= w_cm_nxt;
                        if (w_width_nxt == TIMEOUT_W) begin
                            r_timeout <= 1'b1;
                            r_cnt     <= 32'd0;
                            r_state   <= ST_COOL;
                        end
                    end
                end
                ST_COOL: begin
                    if (i_tick) begin
                        if (r_cnt == COOL_LAST) begin
                            r_cnt   <= 32'd0;
                            r_state <= ST_IDLE;
                        end else begin
                            r_cnt <= r_cnt + 32'd1;
                        end
                    end
                end
                default: begin
                    r_trig  <= 1'b0;
                    r_cnt   <= 32'd0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_trig       = r_trig;
    assign o_cont       = r_cont;
    assign o_busy       = (r_state != ST_IDLE);
    assign o_valid      = r_valid;
    assign o_timeout    = r_timeout;
    assign o_echo_us    = r_echo_us;
    assign o_dist_cm    = r_dist_cm;
    assign o_sample_cnt = r_sample_cnt;

endmodule

// File: rtl/range_sensor_core.sv
// ----------------------------------------------------------------------------
// range_sensor_core
// Bus responder serving N_SENSORS ultrasonic sensor slots of 8 registers each.
// Holds the shared 1 us prescaler, the write decode and the read mux; each
// slot's FSM and registers live in range_sensor_channel.
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   cs_i, wr_i, rd_i      bus select and strobes (cs_i gates both strobes)
//   addr_i[4:3]           sensor index; addr_i[2:0] register index
//   wr_data_i             write data
//   rd_data_o             read data, combinational from registered state
//   trig_o                trigger outputs, one per sensor
//   echo_i                asynchronous echo inputs, one per sensor
// ----------------------------------------------------------------------------
module range_sensor_core #(
    parameter int CLK_FREQ_HZ = 100_000_000,
    parameter int N_SENSORS   = 4,
    parameter int TRIG_US     = 10,
    parameter int TIMEOUT_US  = 30000,
    parameter int CM_DIV_US   = 58,
    parameter int COOL_MS     = 60
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 cs_i,
    input  logic                 wr_i,
    input  logic                 rd_i,
    input  logic [4:0]           addr_i,
    input  logic [31:0]          wr_data_i,
    output logic [31:0]          rd_data_o,
    output logic [N_SENSORS-1:0] trig_o,
    input  logic [N_SENSORS-1:0] echo_i
);
    import range_sensor_pkg::*;

    localparam int          CLK_PER_US = us_per_clk(CLK_FREQ_HZ);
    localparam logic [31:0] PRESC_LAST = 32'(CLK_PER_US - 1);

    logic [31:0] r_presc;
    logic        w_tick;
    logic        w_wr;
    logic [1:0]  w_idx;
    logic        w_unused_wdata;

    logic        w_cont       [N_SENSORS];
    logic        w_busy       [N_SENSORS];
    logic        w_valid      [N_SENSORS];
    logic        w_timeout    [N_SENSORS];
    logic [15:0] w_echo_us    [N_SENSORS];
    logic [9:0]  w_dist_cm    [N_SENSORS];
    logic [15:0] w_sample_cnt [N_SENSORS];

    // Free-running microsecond prescaler shared by all slots
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_presc <= 32'd0;
        end else if (w_tick) begin
            r_presc <= 32'd0;
        end else begin
            r_presc <= r_presc + 32'd1;
        end
    end

    assign w_tick = (r_presc == PRESC_LAST);
    assign w_wr   = cs_i & wr_i;
    assign w_idx  = addr_i[4:3];

    // Only CTRL bits 1:0 carry meaning; the rest of the write word is dropped.
    assign w_unused_wdata = ^wr_data_i[31:2];

    genvar g;
    generate
        for (g = 0; g < N_SENSORS; g++) begin : g_ch
            logic w_sel;
            assign w_sel = w_wr && (addr_i[4:3] == 2'(g));

            range_sensor_channel #(
                .TRIG_US    (TRIG_US),
                .TIMEOUT_US (TIMEOUT_US),
                .CM_DIV_US  (CM_DIV_US),
                .COOL_TICKS (COOL_MS * 1000)
            ) u_ch (
                .i_clk        (clk_i),
                .i_rst        (rst_i),
                .i_tick       (w_tick),
                .i_wr_ctrl    (w_sel && (addr_i[2:0] == REG_CTRL)),
                .i_wr_status  (w_sel && (addr_i[2:0] == REG_STATUS)),
                .i_cont       (wr_data_i[CTRL_CONT_BIT]),
                .i_start      (wr_data_i[CTRL_START_BIT]),
                .i_echo       (echo_i[g]),
                .o_trig       (trig_o[g]),
                .o_cont       (w_cont[g]),
                .o_busy       (w_busy[g]),
                .o_valid      (w_valid[g]),
                .o_timeout    (w_timeout[g]),
                .o_echo_us    (w_echo_us[g]),
                .o_dist_cm    (w_dist_cm[g]),
                .o_sample_cnt (w_sample_cnt[g])
            );
        end
    endgenerate

    // Read mux; START always reads back 0, offsets 5-7 read 0
    always_comb begin
        rd_data_o = 32'd0;
        if (cs_i && rd_i) begin
            case (addr_i[2:0])
                REG_CTRL:       rd_data_o = {31'd0, w_cont[w_idx]};
                REG_STATUS:     rd_data_o = {29'd0, w_timeout[w_idx],
                                             w_valid[w_idx], w_busy[w_idx]};
                REG_ECHO_US:    rd_data_o = {16'd0, w_echo_us[w_idx]};
                REG_DIST_CM:    rd_data_o = {22'd0, w_dist_cm[w_idx]};
                REG_SAMPLE_CNT: rd_data_o = {16'd0, w_sample_cnt[w_idx]};
                default:        rd_data_o = 32'd0;
            endcase
        end else begin
            rd_data_o = 32'd0;
        end
    end

endmodule
